// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU definitions for the common data bus: ROB tag space, invalid tag and
// the queued result entry format.
package cdb_arbiter_pkg;

   localparam int ROB_SIZE = 16;
   localparam int TAG_W    = 6;
   localparam int DATA_W   = 32;

   localparam logic [TAG_W-1:0] INVALID_TAG = 6'b010000;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } cdb_entry_t;

   localparam int ENTRY_W = $bits(cdb_entry_t);

   function automatic logic tag_ok(input logic [TAG_W-1:0] tag);
      return tag < TAG_W'(ROB_SIZE);
   endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-producer result queue: circular buffer with occupancy count and
// synchronous flush.
module cdb_fifo import cdb_arbiter_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty,
   output logic                    full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   typedef logic [CW-1:0] cnt_t;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == cnt_t'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result queues drained onto two
// registered broadcast channels by a round-robin, two-grant scan.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
   parameter int NSRC       = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [NSRC-1:0]          srcValid,
   output logic [NSRC-1:0]          srcReady,
   input  logic [NSRC*TAG_W-1:0]    srcRobNum,
   input  logic [NSRC*DATA_W-1:0]   srcData,
   output logic                     CDBisCast1,
   output logic                     CDBisCast2,
   output logic [TAG_W-1:0]         CDBrobNum1,
   output logic [TAG_W-1:0]         CDBrobNum2,
   output logic [DATA_W-1:0]        CDBdata1,
   output logic [DATA_W-1:0]        CDBdata2
);

   localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   cdb_entry_t       head [NSRC];
   logic [CW-1:0]    cnt  [NSRC];
   logic [NSRC-1:0]  empty;
   logic [NSRC-1:0]  full;
   logic [NSRC-1:0]  push;
   logic [NSRC-1:0]  pop;

   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    scan_idx;
   logic             g1_vld, g2_vld;
   logic [PW-1:0]    g1_idx, g2_idx;

   function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] i);
      return (int'(i) == NSRC - 1) ? '0 : i + 1'b1;
   endfunction

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      cdb_entry_t wr_entry;

      assign wr_entry.tag  = srcRobNum[i*TAG_W +: TAG_W];
      assign wr_entry.data = srcData[i*DATA_W +: DATA_W];
      // Out-of-range tags are accepted but silently dropped.
      assign push[i]       = srcValid[i] && !full[i] && !flush && tag_ok(wr_entry.tag);
      assign srcReady[i]   = (cnt[i] < CW'(FIFO_DEPTH));

      cdb_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (ENTRY_W)
      ) u_cdb_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (push[i]),
         .pop   (pop[i]),
         .wdata (wr_entry),
         .rdata (head[i]),
         .count (cnt[i]),
         .empty (empty[i]),
         .full  (full[i])
      );
   end

   always_comb begin
      g1_vld   = 1'b0;
      g2_vld   = 1'b0;
      g1_idx   = '0;
      g2_idx   = '0;
      scan_idx = '0;
      for (int k = 0; k < NSRC; k++) begin
         scan_idx = PW'((int'(rr_ptr) + k) % NSRC);
         if (!empty[scan_idx]) begin
            if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_idx = scan_idx;
            end else if (!g2_vld) begin
               g2_vld = 1'b1;
               g2_idx = scan_idx;
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      if (g1_vld) pop[g1_idx] = 1'b1;
      if (g2_vld) pop[g2_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         CDBisCast1 <= 1'b0;
         CDBisCast2 <= 1'b0;
         CDBrobNum1 <= INVALID_TAG;
         CDBrobNum2 <= INVALID_TAG;
         CDBdata1   <= '0;
         CDBdata2   <= '0;
      end else if (flush) begin
         rr_ptr     <= '0;
         CDBisCast1 <= 1'b0;
         CDBisCast2 <= 1'b0;
         CDBrobNum1 <= INVALID_TAG;
         CDBrobNum2 <= INVALID_TAG;
         CDBdata1   <= '0;
         CDBdata2   <= '0;
      end else begin
         if (g2_vld)      rr_ptr <= inc_wrap(g2_idx);
         else if (g1_vld) rr_ptr <= inc_wrap(g1_idx);
         CDBisCast1 <= g1_vld;
         CDBisCast2 <= g2_vld;
         CDBrobNum1 <= g1_vld ? head[g1_idx].tag  : INVALID_TAG;
         CDBrobNum2 <= g2_vld ? head[g2_idx].tag  : INVALID_TAG;
         CDBdata1   <= g1_vld ? head[g1_idx].data : '0;
         CDBdata2   <= g2_vld ? head[g2_idx].data : '0;
      end
   end

endmodule
